instr_fetch_unit: RTL and testbench

//  Producer side of the control_path opCode interface. Fetches 32-bit instructions from instruction memory and

---
 rtl/instr_fetch_unit_if.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Bundles the fetch unit's two bus faces:
//                - control_path side: enPC / muxPC / dirPC in,
//                  opCode / opValid / opPC out
//                - instruction-memory side: memReq / memAddr out,
//                  memReady / memData in
//                master = fetch unit, slave = its environment
//                (control_path plus instruction memory).
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int BUS_SIZE = 32,
    parameter int DIR_SIZE = 32
);
    // control_path handshake
    logic                enPC;
    logic                muxPC;
    logic [DIR_SIZE-1:0] dirPC;
    logic [BUS_SIZE-1:0] opCode;
    logic                opValid;
    logic [DIR_SIZE-1:0] opPC;

    // instruction memory read port
    logic                memReq;
    logic [DIR_SIZE-1:0] memAddr;
    logic                memReady;
    logic [BUS_SIZE-1:0] memData;

    modport master (
        input  enPC, muxPC, dirPC, memReady, memData,
        output opCode, opValid, opPC, memReq, memAddr
    );

    modport slave (
        output enPC, muxPC, dirPC, memReady, memData,
        input  opCode, opValid, opPC, memReq, memAddr
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetches 32-bit instructions from instruction memory into a
//                small FIFO and presents the head entry to control_path.
//                One memory read is outstanding at most; a redirect (muxPC)
//                flushes the FIFO and restarts fetching at dirPC. A redirect
//                arriving while a read is still pending parks the FSM in DROP
//                until that read completes, so its data is discarded.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                bus (master)        - enPC/muxPC/dirPC in, opCode/opValid/
//                                      opPC out, memReq/memAddr out,
//                                      memReady/memData in
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int                  BUS_SIZE   = 32,
    parameter int                  DIR_SIZE   = 32,
    parameter logic [DIR_SIZE-1:0] RESET_PC   = '0,
    parameter int                  FIFO_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    instr_fetch_unit_if.master bus
);

    localparam int                  c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH   = c_CNT_W'(FIFO_DEPTH);
    localparam logic [DIR_SIZE-1:0] c_PC_STEP = DIR_SIZE'(4);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_REQ  = 2'd1,
        c_DROP = 2'd2
    } state_t;

    state_t              r_state;
    logic [DIR_SIZE-1:0] r_fetchPC;
    logic                r_memReq;
    logic [DIR_SIZE-1:0] r_memAddr;

    logic [BUS_SIZE-1:0] r_fifoData [FIFO_DEPTH];
    logic [DIR_SIZE-1:0] r_fifoPC   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic [c_CNT_W-1:0]  w_countNext;
    logic [DIR_SIZE-1:0] w_target;
    logic [DIR_SIZE-1:0] w_pcInc;
    logic                w_unusedDirBits;

    // Redirect wins over both consume and fill: a flushed FIFO must not pop
    // a stale head nor accept the word that was in flight.
    assign w_valid     = (r_count != '0);
    assign w_pop       = bus.enPC & w_valid & ~bus.muxPC;
    assign w_push      = (r_state == c_REQ) & bus.memReady & ~bus.muxPC;
    assign w_countNext = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign w_target    = {bus.dirPC[DIR_SIZE-1:2], 2'b00};
    assign w_pcInc     = r_fetchPC + c_PC_STEP;

    // Low target bits are forced to zero and never used.
    assign w_unusedDirBits = &{1'b0, bus.dirPC[1:0]};

    // ------------------------------------------------------------------
    // Fetch FSM. memAddr tracks fetchPC except in DROP, where it keeps the
    // address of the read that is still pending so memory sees a stable
    // request until memReady.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_fetchPC <= RESET_PC;
            r_memReq  <= 1'b0;
            r_memAddr <= RESET_PC;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.muxPC) begin
                        r_fetchPC <= w_target;
                        r_memAddr <= w_target;
                    end else if (r_count < c_DEPTH) begin
                        r_state  <= c_REQ;
                        r_memReq <= 1'b1;
                    end
                end

                c_REQ: begin
                    if (bus.muxPC) begin
                        r_fetchPC <= w_target;
                        if (bus.memReady) begin
                            r_state   <= c_IDLE;
                            r_memReq  <= 1'b0;
                            r_memAddr <= w_target;
                        end else begin
                            // Read still pending: hold old address in DROP.
                            r_state <= c_DROP;
                        end
                    end else if (bus.memReady) begin
                        r_fetchPC <= w_pcInc;
                        r_memAddr <= w_pcInc;
                        // Keep streaming only while a slot is free after this
                        // cycle's push/pop; this is what prevents overflow.
                        if (w_countNext >= c_DEPTH) begin
                            r_state  <= c_IDLE;
                            r_memReq <= 1'b0;
                        end
                    end
                end

                c_DROP: begin
                    if (bus.muxPC) begin
                        r_fetchPC <= w_target;
                    end
                    if (bus.memReady) begin
                        r_state   <= c_IDLE;
                        r_memReq  <= 1'b0;
                        r_memAddr <= bus.muxPC ? w_target : r_fetchPC;
                    end
                end

                default: begin
                    r_state   <= c_IDLE;
                    r_memReq  <= 1'b0;
                    r_memAddr <= r_fetchPC;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Instruction buffer bookkeeping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || bus.muxPC) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
            r_count <= w_countNext;
        end
    end

    // Storage needs no reset: entries are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_fifoData[r_wrPtr] <= bus.memData;
            r_fifoPC[r_wrPtr]   <= r_fetchPC;
        end
    end

    assign bus.opValid = w_valid;
    assign bus.opCode  = w_valid ? r_fifoData[r_rdPtr] : '0;
    assign bus.opPC    = w_valid ? r_fifoPC[r_rdPtr]   : '0;
    assign bus.memReq  = r_memReq;
    assign bus.memAddr = r_memAddr;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. A reactive memory
//                model answers requests after a programmable latency; every
//                accepted word is pushed to a scoreboard queue and compared
//                against the FIFO head as control_path consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          BUS_SIZE   = 32;
    localparam int          DIR_SIZE   = 32;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_fetch_unit_if #(.BUS_SIZE(BUS_SIZE), .DIR_SIZE(DIR_SIZE)) bus();

    instr_fetch_unit #(
        .BUS_SIZE  (BUS_SIZE),
        .DIR_SIZE  (DIR_SIZE),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] code;
    } entry_t;

    entry_t      sb[$];
    int          nVec = 0;
    int          nErr = 0;
    int          lat = 0;
    int          waitCnt = 0;
    int          armMode = 0;
    logic [31:0] armDir = '0;
    bit          dropPending = 1'b0;
    logic [31:0] dropAddr = '0;
    logic [31:0] expFetch = RESET_PC;
    int          sinceRst = 0;
    int          nPops = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'hBEEF};
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge, drive inputs, predict the edge.
    task automatic cycle(input bit doRst, input bit doEn, input bit doMux, input logic [31:0] dir);
        bit          req, rdy, mx;
        logic [31:0] addr, dv;
        @(negedge clk);
        req  = bus.memReq;
        addr = bus.memAddr;

        checkEq("opValid", 32'(bus.opValid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            checkEq("opPC", bus.opPC, sb[0].pc);
            checkEq("opCode", bus.opCode, sb[0].code);
        end else begin
            checkEq("opPC_empty", bus.opPC, 32'h0);
            checkEq("opCode_empty", bus.opCode, 32'h0);
        end
        if (sinceRst == 0) begin
            checkEq("rst_memReq", 32'(req), 32'h0);
            checkEq("rst_memAddr", addr, RESET_PC);
        end else if (sinceRst == 1) begin
            checkEq("first_memReq", 32'(req), 32'h1);
        end
        if (req) checkEq("memAddr", addr, dropPending ? dropAddr : expFetch);
        if (sb.size() == FIFO_DEPTH) checkEq("full_memReq", 32'(req), 32'h0);

        // memory model
        rdy = 1'b0;
        if (req) begin
            if (waitCnt >= lat) begin
                rdy = 1'b1;
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end

        mx = doMux;
        dv = dir;
        if (armMode == 1 && req && !rdy) begin
            mx = 1'b1; dv = armDir; armMode = 0;
        end else if (armMode == 2 && sb.size() == FIFO_DEPTH) begin
            mx = 1'b1; dv = armDir; armMode = 0;
        end

        rst          = doRst;
        bus.enPC     = doEn;
        bus.muxPC    = mx;
        bus.dirPC    = dv;
        bus.memReady = rdy;
        bus.memData  = rdy ? memWord(addr) : 32'h0;

        // expected effect of the coming edge
        if (doRst) begin
            sb.delete();
            expFetch    = RESET_PC;
            dropPending = 1'b0;
            waitCnt     = 0;
            sinceRst    = 0;
        end else begin
            sinceRst++;
            if (mx) begin
                sb.delete();
                if (req && !rdy) begin
                    if (!dropPending) dropAddr = addr;
                    dropPending = 1'b1;
                end else if (rdy) begin
                    dropPending = 1'b0;
                end
                expFetch = {dv[31:2], 2'b00};
            end else begin
                if (doEn && sb.size() != 0) begin
                    void'(sb.pop_front());
                    nPops++;
                end
                if (rdy) begin
                    if (dropPending) begin
                        dropPending = 1'b0;
                    end else begin
                        sb.push_back({addr, memWord(addr)});
                        expFetch = expFetch + 32'd4;
                    end
                end
            end
        end
    endtask

    initial begin
        int popsStart;
        bus.enPC     = 1'b0;
        bus.muxPC    = 1'b0;
        bus.dirPC    = '0;
        bus.memReady = 1'b0;
        bus.memData  = '0;

        repeat (3) cycle(1, 0, 0, 32'h0);

        // 1: fill with enPC=0, then stall
        repeat (6) cycle(0, 0, 0, 32'h0);
        checkEq("t1_fill", 32'(sb.size()), 32'(FIFO_DEPTH));
        checkEq("t1_head", sb.size() != 0 ? sb[0].pc : 32'hFFFF_FFFF, 32'h0);

        // 2: continuous consume, zero-wait memory
        popsStart = nPops;
        repeat (12) cycle(0, 1, 0, 32'h0);
        checkEq("t2_rate", 32'((nPops - popsStart) >= 8), 32'h1);

        // 3: three wait cycles per request
        lat = 3;
        repeat (30) cycle(0, 1, 0, 32'h0);

        // 4: redirect while a read is pending
        armMode = 1;
        armDir  = 32'h0000_0103;
        for (int i = 0; i < 20 && armMode != 0; i++) cycle(0, 1, 0, 32'h0);
        checkEq("t4_redirect_issued", armMode, 0);
        checkEq("t4_drop", 32'(dropPending), 32'h1);
        repeat (25) cycle(0, 1, 0, 32'h0);

        // 5: redirect with consume while FIFO is full
        lat = 0;
        repeat (5) cycle(0, 0, 0, 32'h0);
        armMode = 2;
        armDir  = 32'h0000_0200;
        for (int i = 0; i < 10 && armMode != 0; i++) cycle(0, 1, 0, 32'h0);
        checkEq("t5_redirect_issued", armMode, 0);
        repeat (10) cycle(0, 1, 0, 32'h0);

        // 6: reset while streaming (request completing at the same edge)
        cycle(1, 1, 0, 32'h0);
        cycle(1, 0, 0, 32'h0);
        repeat (8) cycle(0, 1, 0, 32'h0);

        // mixed traffic
        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(0, 2);
            cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  32'($urandom_range(0, 1023)));
        end
        repeat (10) cycle(0, 1, 0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
